// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer for the single-cycle CPU core.
//
// The core no longer sees a divided clock. It sees a one-clk execute enable
// (cpu_en_o), issued one clk after a divider tick (tick_i) whenever the
// sequencer is running or stepping. Also provided: external halt, an
// optional PC breakpoint, and a saturating count of executed instructions.
//
// Optional feature macro: RUN_CTRL_BP_EN
//   defined   : breakpoint compare, skip-past-breakpoint flag and bp_hit_o
//   undefined : no compare logic; bp_hit_o tied 0; HALT only via halt_i
//
// state_o encoding: 00 IDLE, 01 RUN, 10 STEP, 11 HALT.

module cpu_run_ctrl #(
    parameter int PC_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_i,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             cpu_en_o,
    output logic [1:0]       state_o,
    output logic             bp_hit_o,
    output logic [CNT_W-1:0] inst_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic               cpu_en;
    logic [CNT_W-1:0]   cnt;
    logic               step_q;
    logic               run_q;

    // Decisions made by the next-state logic for the coming edge.
    logic               issue;
    logic               bp_set;
    logic               bp_clr;
    logic               skip_set;

    logic               step_req;
    logic               run_rise;
    logic               match;

    // One request per rising edge of the step level; holding it is one request.
    assign step_req = step_i & ~step_q;
    // Leaving HALT for RUN needs a fresh run request, not a held level.
    assign run_rise = run_i & ~run_q;

`ifdef RUN_CTRL_BP_EN
    logic bp_hit;
    logic skip;

    // Breakpoint hit: enabled, PC equal, and not the instruction we just
    // resumed from (skip lets execution step past the breakpoint PC).
    assign match = bp_en_i & (pc_i == bp_addr_i) & ~skip;

    // Sticky breakpoint flag and the skip-once flag set on every HALT exit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bp_hit <= 1'b0;
            skip   <= 1'b0;
        end else begin
            if (bp_set)
                bp_hit <= 1'b1;
            else if (bp_clr)
                bp_hit <= 1'b0;

            if (skip_set)
                skip <= 1'b1;
            else if (issue)
                skip <= 1'b0;
        end
    end
`else
    logic unused_bp;

    assign match     = 1'b0;
    assign unused_bp = ^{bp_en_i, bp_addr_i, pc_i, bp_set, bp_clr, skip_set};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Enable pulse, saturating instruction counter and input edge history.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cpu_en <= 1'b0;
            cnt    <= '0;
            step_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            cpu_en <= issue;
            if (issue && (cnt != '1))
                cnt <= cnt + CNT_W'(1);
            step_q <= step_i;
            run_q  <= run_i;
        end
    end

    // Next-state and issue decision; priority halt > breakpoint > run/step > tick.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        bp_set   = 1'b0;
        bp_clr   = 1'b0;
        skip_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (halt_i)
                    state_nx = HALT;
                else if (run_i)
                    state_nx = RUN;
                else if (step_req)
                    state_nx = STEP;
            end
            RUN: begin
                if (halt_i) begin
                    state_nx = HALT;
                    bp_clr   = 1'b1;
                end else if (tick_i && match) begin
                    // The matching instruction is not executed.
                    state_nx = HALT;
                    bp_set   = 1'b1;
                end else if (!run_i) begin
                    state_nx = IDLE;
                end else if (tick_i && !cpu_en) begin
                    // Back-to-back ticks never produce back-to-back enables.
                    issue = 1'b1;
                end
            end
            STEP: begin
                if (halt_i) begin
                    state_nx = HALT;
                end else if (tick_i && match) begin
                    state_nx = HALT;
                    bp_set   = 1'b1;
                end else if (tick_i) begin
                    issue    = 1'b1;
                    state_nx = IDLE;
                end
            end
            HALT: begin
                if (!halt_i) begin
                    if (step_req) begin
                        state_nx = STEP;
                        bp_clr   = 1'b1;
                        skip_set = 1'b1;
                    end else if (run_rise) begin
                        state_nx = RUN;
                        bp_clr   = 1'b1;
                        skip_set = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are straight from registers.
    always_comb begin
        cpu_en_o   = cpu_en;
        state_o    = state;
        inst_cnt_o = cnt;
`ifdef RUN_CTRL_BP_EN
        bp_hit_o   = bp_hit;
`else
        bp_hit_o   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl. A behavioural model advances once per
// clk as stimulus is driven and queues the expected post-edge outputs; a
// monitor pops one entry after each rising edge and compares.
// Built with CNT_W=8 so counter saturation is reachable in a short run.

module tb_cpu_run_ctrl;

    localparam int PC_W    = 6;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PC_MOD  = (1 << PC_W);
`ifdef RUN_CTRL_BP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             tick_i = 1'b0;
    logic             run_i = 1'b0;
    logic             step_i = 1'b0;
    logic             halt_i = 1'b0;
    logic             bp_en_i = 1'b0;
    logic [PC_W-1:0]  bp_addr_i = '0;
    logic [PC_W-1:0]  pc_i = '0;
    logic             cpu_en_o;
    logic [1:0]       state_o;
    logic             bp_hit_o;
    logic [CNT_W-1:0] inst_cnt_o;

    cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_i     (tick_i),
        .run_i      (run_i),
        .step_i     (step_i),
        .halt_i     (halt_i),
        .bp_en_i    (bp_en_i),
        .bp_addr_i  (bp_addr_i),
        .pc_i       (pc_i),
        .cpu_en_o   (cpu_en_o),
        .state_o    (state_o),
        .bp_hit_o   (bp_hit_o),
        .inst_cnt_o (inst_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic [1:0]       st;
        logic             bp;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    bit   stim_done = 1'b0;

    // Reference model state
    int m_mode = M_IDLE;
    bit m_bp = 0, m_skip = 0, m_en = 0, m_sprev = 0, m_rprev = 0;
    int m_cnt = 0;
    int m_pc = 0;

    // One clk of stimulus; the model computes what the coming edge produces.
    task automatic cyc(input bit r, input bit t, input bit ru, input bit s,
                       input bit h, input bit be, input int ba);
        bit   step_req, run_rise, match, go;
        exp_t e;
        @(negedge clk);
        rstn      = r;
        tick_i    = t;
        run_i     = ru;
        step_i    = s;
        halt_i    = h;
        bp_en_i   = be;
        bp_addr_i = ba[PC_W-1:0];
        pc_i      = m_pc[PC_W-1:0];
        // The core advances its PC on the edge where the enable is visible.
        if (m_en) m_pc = (m_pc + 1) % PC_MOD;
        if (!r) begin
            m_mode = M_IDLE; m_bp = 0; m_skip = 0; m_en = 0;
            m_cnt = 0; m_sprev = 0; m_rprev = 0;
        end else begin
            step_req = s && !m_sprev;
            run_rise = ru && !m_rprev;
            match    = BP && be && (ba == m_pc_before(pc_i)) && !m_skip;
            go       = 0;
            if (m_mode == M_IDLE) begin
                if (h) m_mode = M_HALT;
                else if (ru) m_mode = M_RUN;
                else if (step_req) m_mode = M_STEP;
            end else if (m_mode == M_RUN) begin
                if (h) begin m_mode = M_HALT; m_bp = 0; end
                else if (t && match) begin m_mode = M_HALT; m_bp = 1; end
                else if (!ru) m_mode = M_IDLE;
                else if (t) go = 1;
            end else if (m_mode == M_STEP) begin
                if (h) m_mode = M_HALT;
                else if (t && match) begin m_mode = M_HALT; m_bp = 1; end
                else if (t) begin go = 1; m_mode = M_IDLE; end
            end else begin
                if (!h && step_req) begin m_mode = M_STEP; m_bp = 0; m_skip = 1; end
                else if (!h && run_rise) begin m_mode = M_RUN; m_bp = 0; m_skip = 1; end
            end
            m_en = go;
            if (go) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                m_skip = 0;
            end
            m_sprev = s;
            m_rprev = ru;
        end
        e.en  = m_en;
        e.st  = m_mode[1:0];
        e.bp  = m_bp;
        e.cnt = m_cnt[CNT_W-1:0];
        q.push_back(e);
    endtask

    function automatic int m_pc_before(input logic [PC_W-1:0] p);
        return int'(p);
    endfunction

    // n ticks spaced gap clks apart with the other inputs held.
    task automatic ticks(input int n, input int gap, input bit ru, input bit s,
                         input bit h, input bit be, input int ba);
        for (int i = 0; i < n; i++) begin
            cyc(1, 1, ru, s, h, be, ba);
            for (int j = 1; j < gap; j++) cyc(1, 0, ru, s, h, be, ba);
        end
    endtask

    // Monitor: one expected entry per rising edge once stimulus has begun.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (cpu_en_o !== e.en || state_o !== e.st ||
                    bp_hit_o !== e.bp || inst_cnt_o !== e.cnt)
                    $display("FAIL cycle t=%0t got en=%b st=%b bp=%b cnt=%0d exp en=%b st=%b bp=%b cnt=%0d",
                             $time, cpu_en_o, state_o, bp_hit_o, inst_cnt_o,
                             e.en, e.st, e.bp, e.cnt);
                else
                    passes++;
            end
        end
    end

    initial begin
        bit r, t, ru, s, h, be, last_t;
        int ba;

        // Reset
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

        // Continuous run: 10 ticks every 4 clks, then drop run back to IDLE
        cyc(1, 0, 1, 0, 0, 0, 0);
        ticks(10, 4, 1, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);

        // Step held high for 20 clks across 3 ticks: one instruction only
        for (int i = 0; i < 20; i++) cyc(1, (i % 6) == 2, 0, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);

        // Breakpoint at PC 5 while running, then one step past it
        m_pc = 0;
        cyc(1, 0, 1, 0, 0, 1, 5);
        ticks(10, 3, 1, 0, 0, 1, 5);
        repeat (3) cyc(1, 0, 0, 0, 0, 1, 5);
        cyc(1, 0, 0, 1, 0, 1, 5);
        cyc(1, 0, 0, 0, 0, 1, 5);
        ticks(3, 3, 0, 0, 0, 1, 5);

        // halt and tick together during RUN, then held run cannot resume
        cyc(1, 0, 1, 0, 0, 0, 0);
        ticks(2, 3, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0);
        repeat (2) cyc(1, 0, 1, 0, 1, 0, 0);
        ticks(3, 2, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        ticks(3, 3, 1, 0, 0, 0, 0);

        // Reset on the clk after a tick while running
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

        // Randomised traffic
        r = 1; ru = 0; s = 0; h = 0; be = 0; ba = 0; last_t = 0;
        for (int i = 0; i < 3000; i++) begin
            t = !last_t && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) ru = !ru;
            if ($urandom_range(0, 5) == 0) s = !s;
            if (h) h = ($urandom_range(0, 3) != 0);
            else   h = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) begin
                be = $urandom_range(0, 1);
                ba = $urandom_range(0, PC_MOD - 1);
            end
            r = ($urandom_range(0, 499) != 0);
            cyc(r, t, ru, s, h, be, ba);
            last_t = t;
        end

        // Counter saturation: 300 instructions into an 8-bit counter
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        ticks(300, 2, 1, 0, 0, 0, 0);
        repeat (2) cyc(1, 0, 1, 0, 0, 0, 0);

        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0)
            $display("FAIL drain got %0d left exp 0", q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
